// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register indices, SR/Cause bit positions, exception codes and EPC helper.
package cp0_pkg;
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam int SR_IE       = 0;
  localparam int SR_EXL      = 1;
  localparam int IM_LO       = 10;
  localparam int IM_HI       = 15;
  localparam int CAUSE_BD    = 31;
  localparam int CAUSE_TI    = 30;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  function automatic logic [31:0] epc_target(input logic [31:0] vpc, input logic bd);
    logic [31:0] v;
    v = bd ? vpc - 32'd4 : vpc;
    return {v[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/cp0_timer_ext_if.sv
// cp0_timer_ext_if: pipeline-side signals of the CP0 block.
interface cp0_timer_ext_if #(parameter int NUM_HWINT = 6);
  logic                 en;
  logic [4:0]           CP0Add;
  logic [31:0]          CP0In;
  logic [31:0]          CP0Out;
  logic [31:0]          VPC;
  logic                 BDIn;
  logic [4:0]           ExcCodeIn;
  logic [31:0]          BadVAddrIn;
  logic [NUM_HWINT-1:0] HWInt;
  logic                 EXLClr;
  logic [31:0]          EPCOut;
  logic                 Req;
  logic                 TimerIrq;
  modport master (output en, CP0Add, CP0In, VPC, BDIn, ExcCodeIn, BadVAddrIn, HWInt, EXLClr,
                  input CP0Out, EPCOut, Req, TimerIrq);
  modport slave (input en, CP0Add, CP0In, VPC, BDIn, ExcCodeIn, BadVAddrIn, HWInt, EXLClr,
                 output CP0Out, EPCOut, Req, TimerIrq);
endinterface

// File: rtl/cp0_count_timer.sv
// cp0_count_timer: prescaled Count, Compare and the sticky timer interrupt TI.
module cp0_count_timer #(parameter int COUNT_DIV = 1) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_count_we,
  input  logic        i_compare_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_ti
);
  logic [3:0]  r_pre;
  logic [31:0] r_count, r_compare;
  logic        r_ti, w_tick;
  assign w_tick = r_pre == 4'(COUNT_DIV - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_pre     <= '0;
      r_count   <= '0;
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else begin
      r_pre     <= (i_count_we || w_tick) ? 4'd0 : r_pre + 4'd1;
      r_count   <= i_count_we ? i_wdata : w_tick ? r_count + 32'd1 : r_count;
      r_compare <= i_compare_we ? i_wdata : r_compare;
      // compare write clears TI even if the match would set it on this edge
      r_ti      <= ~i_compare_we & (r_ti | (r_count == r_compare));
    end
  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ti      = r_ti;
endmodule

// File: rtl/cp0_timer_ext.sv
// cp0_timer_ext: MIPS CP0 with SR/Cause/EPC/BadVAddr/PRId, exception request and
// Count/Compare timer sharing IP7.
module cp0_timer_ext
  import cp0_pkg::*;
#(
  parameter int          NUM_HWINT = 6,
  parameter int          TIMER_EN  = 1,
  parameter int          COUNT_DIV = 1,
  parameter logic [31:0] PRID_VAL  = 32'h0000_0001
) (
  input logic clk,
  input logic reset,
  cp0_timer_ext_if.slave bus
);
  logic        r_ie, r_exl, r_bd;
  logic [5:0]  r_im, r_ip;
  logic [4:0]  r_exc;
  logic [31:0] r_epc, r_badv, w_rdata, w_epc_new, w_count, w_compare;
  logic [5:0]  w_pend;
  logic        w_ti, w_int, w_exc, w_req, w_sr_we, w_epc_we, w_count_we, w_compare_we, w_badv_we;
  assign w_sr_we      = bus.en && bus.CP0Add == REG_SR;
  assign w_epc_we     = bus.en && bus.CP0Add == REG_EPC;
  assign w_count_we   = bus.en && bus.CP0Add == REG_COUNT;
  assign w_compare_we = bus.en && bus.CP0Add == REG_COMPARE;
  if (TIMER_EN != 0) begin : g_timer
    cp0_count_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
      .clk          (clk),
      .reset        (reset),
      .i_count_we   (w_count_we),
      .i_compare_we (w_compare_we),
      .i_wdata      (bus.CP0In),
      .o_count      (w_count),
      .o_compare    (w_compare),
      .o_ti         (w_ti)
    );
  end else begin : g_no_timer
    assign w_count   = '0;
    assign w_compare = '0;
    assign w_ti      = 1'b0;
  end
  // TI lands on IP7 and ORs with the top hardware line when all six exist
  assign w_pend    = 6'(bus.HWInt[NUM_HWINT-1:0]) | {w_ti, 5'b0};
  assign w_int     = |(w_pend & r_im) & r_ie & ~r_exl;
  assign w_exc     = (bus.ExcCodeIn != EXC_INT) & ~r_exl;
  assign w_req     = w_int | w_exc;
  assign w_epc_new = epc_target(bus.VPC, bus.BDIn);
  assign w_badv_we = w_req && !w_int && (bus.ExcCodeIn == EXC_ADEL || bus.ExcCodeIn == EXC_ADES);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_ie   <= 1'b0;
      r_exl  <= 1'b0;
      r_im   <= '0;
      r_ip   <= '0;
      r_bd   <= 1'b0;
      r_exc  <= '0;
      r_epc  <= '0;
      r_badv <= '0;
    end else begin
      r_ie   <= w_sr_we ? bus.CP0In[SR_IE] : r_ie;
      r_im   <= w_sr_we ? bus.CP0In[IM_HI:IM_LO] : r_im;
      r_exl  <= w_req | (w_sr_we ? bus.CP0In[SR_EXL] : r_exl & ~bus.EXLClr);
      r_ip   <= w_pend;
      r_bd   <= w_req ? bus.BDIn : r_bd;
      r_exc  <= w_req ? (w_int ? EXC_INT : bus.ExcCodeIn) : r_exc;
      r_epc  <= w_req ? w_epc_new : w_epc_we ? bus.CP0In : r_epc;
      r_badv <= w_badv_we ? bus.BadVAddrIn : r_badv;
    end
  always_comb begin
    w_rdata = '0;
    case (bus.CP0Add)
      REG_BADVADDR: w_rdata = r_badv;
      REG_COUNT:    w_rdata = w_count;
      REG_COMPARE:  w_rdata = w_compare;
      REG_SR:       w_rdata = {16'b0, r_im, 8'b0, r_exl, r_ie};
      REG_CAUSE:    w_rdata = {r_bd, w_ti, 14'b0, r_ip, 3'b0, r_exc, 2'b0};
      REG_EPC:      w_rdata = r_epc;
      REG_PRID:     w_rdata = PRID_VAL;
      default:      w_rdata = '0;
    endcase
  end
  assign bus.CP0Out   = w_rdata;
  assign bus.EPCOut   = w_req ? w_epc_new : r_epc;
  assign bus.Req      = w_req;
  assign bus.TimerIrq = w_ti;
endmodule
